// File: rtl/sti_cmd_sequencer.sv
// sti_cmd_sequencer: buffers host commands and issues one STI_DAC transfer per command,
// tracking completion by so_valid bits. Optional watchdog enabled by defining STI_WDOG_EN.
module sti_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    input  logic [1:0]  cmd_len,
    input  logic        cmd_fill,
    input  logic        cmd_msb,
    input  logic        cmd_low,
    input  logic        cmd_last,
    output logic        load,
    output logic [15:0] pi_data,
    output logic [1:0]  pi_length,
    output logic        pi_fill,
    output logic        pi_msb,
    output logic        pi_low,
    output logic        pi_end,
    input  logic        so_valid,
    input  logic        oem_finish,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    // Entry layout: {last, low, msb, fill, len[1:0], data[15:0]}
    logic [21:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [4:0]    r_bits;
    logic          r_done;
    logic [15:0]   r_pi_data;
    logic [1:0]    r_pi_length;
    logic          r_pi_fill;
    logic          r_pi_msb;
    logic          r_pi_low;
    logic          r_pi_end;
    logic [21:0]   w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_last_bit;
    logic          w_shifting;
    logic          w_timeout;

    assign w_head     = r_mem[r_rptr];
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign cmd_ready  = !w_full && !reset;
    assign w_push     = cmd_valid && cmd_ready;
    assign w_shifting = (r_state == S_WAIT) || (r_state == S_SHIFT);
    assign w_last_bit = (r_state == S_SHIFT) && so_valid && (r_bits == '0);
    // A watchdog expiry in WAIT/SHIFT drops the head; in FIN it was already popped.
    assign w_pop      = w_last_bit || (w_timeout && w_shifting);

    assign load      = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign pi_data   = r_pi_data;
    assign pi_length = r_pi_length;
    assign pi_fill   = r_pi_fill;
    assign pi_msb    = r_pi_msb;
    assign pi_low    = r_pi_low;
    assign pi_end    = r_pi_end;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next = S_LOAD;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT:  if (so_valid) w_next = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_next = r_pi_end ? S_FIN : S_GAP;
            S_GAP:   w_next = w_empty ? S_IDLE : S_LOAD;
            S_FIN:   if (oem_finish) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {cmd_last, cmd_low, cmd_msb, cmd_fill, cmd_len, cmd_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_bits      <= '0;
            r_done      <= 1'b0;
            r_pi_data   <= '0;
            r_pi_length <= '0;
            r_pi_fill   <= 1'b0;
            r_pi_msb    <= 1'b0;
            r_pi_low    <= 1'b0;
            r_pi_end    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_FIN) && oem_finish;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Capture on entry so pi_* are already valid during the load strobe.
            if (w_next == S_LOAD) begin
                r_pi_data   <= w_head[15:0];
                r_pi_length <= w_head[17:16];
                r_pi_fill   <= w_head[18];
                r_pi_msb    <= w_head[19];
                r_pi_low    <= w_head[20];
                r_pi_end    <= w_head[21];
                r_bits      <= {w_head[17:16], 3'b111};
            end else if (w_shifting && so_valid && (r_bits != '0)) begin
                r_bits <= r_bits - 1'b1;
            end
        end
    end

`ifdef STI_WDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_wdog;
    logic          r_err;
    logic          w_wd_act;

    // Counts only idle cycles of a waiting state; any progress or state exit clears it.
    assign w_wd_act  = w_shifting ? !so_valid : ((r_state == S_FIN) && !oem_finish);
    assign w_timeout = w_wd_act && (r_wdog == TW'(TIMEOUT - 1));
    assign err       = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (!w_wd_act || w_timeout) r_wdog <= '0;
            else                        r_wdog <= r_wdog + 1'b1;
            if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    // TIMEOUT only matters when the watchdog is built in.
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_sti_cmd_sequencer.sv
// Self-checking bench for sti_cmd_sequencer: scoreboard of pushed commands checked at each
// load strobe, plus a simple STI model that returns 8*(len+1) so_valid bits per transfer.
module tb_sti_cmd_sequencer;
    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_len;
    logic        cmd_fill;
    logic        cmd_msb;
    logic        cmd_low;
    logic        cmd_last;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        so_valid;
    logic        oem_finish;
    logic        busy;
    logic        done;
    logic        err;
    logic [21:0] w_pi;

    sti_cmd_sequencer #(.DEPTH(4), .AW(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .cmd_fill(cmd_fill), .cmd_msb(cmd_msb), .cmd_low(cmd_low), .cmd_last(cmd_last),
        .load(load), .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_valid(so_valid), .oem_finish(oem_finish),
        .busy(busy), .done(done), .err(err)
    );

    assign w_pi = {pi_end, pi_low, pi_msb, pi_fill, pi_length, pi_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard and monitor
    logic [21:0] exp_q[$];
    int          load_cyc[$];
    logic [21:0] snap = '0;
    int          n_load = 0;
    int          n_done = 0;
    int          hold_err = 0;
    int          last_busy_cyc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (load) begin
                n_load++;
                load_cyc.push_back(cyc);
                snap = w_pi;
                chk("load_has_exp", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("pi_fields", 32'(w_pi), 32'(exp_q.pop_front()));
            end else if (busy && (w_pi !== snap)) begin
                hold_err++;
            end
            if (busy) last_busy_cyc = cyc;
            if (done) n_done++;
        end
    end

    // STI model: one dead WAIT cycle after load, then the bits (optionally 1-on/1-off).
    bit sti_en = 1'b1;
    bit sti_gap = 1'b0;
    int sti_xfers = 0;
    initial begin
        so_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (load && !reset && sti_en) begin
                int nb;
                nb = 8 * (int'(pi_length) + 1);
                repeat (2) @(negedge clk);
                for (int b = 0; b < nb && !reset; b++) begin
                    so_valid = 1'b1;
                    @(negedge clk);
                    if (sti_gap) begin
                        so_valid = 1'b0;
                        @(negedge clk);
                    end
                end
                so_valid = 1'b0;
                if (!reset) sti_xfers++;
            end
        end
    end

    task automatic drive_cmd(input logic [15:0] d, input logic [1:0] len,
                             input logic f, input logic m, input logic lo, input logic la);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_len   = len;
        cmd_fill  = f;
        cmd_msb   = m;
        cmd_low   = lo;
        cmd_last  = la;
        exp_q.push_back({la, lo, m, f, len, d});
        @(negedge clk);
    endtask

    task automatic wait_loads(input int target, input string tag);
        int t = 0;
        while (n_load < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(n_load >= target), 1);
    endtask

    task automatic wait_xfers(input int target, input string tag);
        int t = 0;
        while (sti_xfers < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(sti_xfers >= target), 1);
    endtask

    task automatic finish_frame(input string tag);
        @(negedge clk);
        oem_finish = 1'b1;
        @(negedge clk);
        oem_finish = 1'b0;
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_idle"}, 32'(busy), 0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0;
        int b;
        int k;
        int nd;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_data   = '0;
        cmd_len    = '0;
        cmd_fill   = 1'b0;
        cmd_msb    = 1'b0;
        cmd_low    = 1'b0;
        cmd_last   = 1'b0;
        oem_finish = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({load, busy, done, err, cmd_ready, w_pi}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 1);

        // oem_finish while idle must not produce done
        oem_finish = 1'b1;
        @(negedge clk);
        oem_finish = 1'b0;
        chk("oem_idle_done", 32'(done), 0);
        chk("oem_idle_busy", 32'(busy), 0);

        // 1: single 8b command
        b  = n_load;
        c0 = cyc;
        drive_cmd(16'hA5C3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        wait_loads(b + 1, "t1_load");
        chk("t1_latency", 32'(load_cyc[b] - c0), 2);
        wait_xfers(1, "t1_xfer");
        finish_frame("t1");

        // 2+3: four 16b commands back-to-back, then a push held over the first pop
        b = n_load;
        drive_cmd(16'h1111, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cmd(16'h2222, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cmd(16'h3333, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_cmd(16'h4444, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        cmd_data = 16'hDEAD;
        cmd_last = 1'b0;
        chk("t2_full", 32'(cmd_ready), 0);
        k = load_cyc[b];
        while (cyc < k + 17) @(negedge clk);
        chk("t3_full_prepop", 32'(cmd_ready), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t3_occ3_ready", 32'(cmd_ready), 1);
        wait_xfers(5, "t2_xfer");
        finish_frame("t2");
        chk("t2_load_count", 32'(n_load - b), 4);
        for (int i = 0; i < 3; i++) chk("t2_spacing", 32'(load_cyc[b+i+1] - load_cyc[b+i]), 19);
        chk("t3_no_refused_entry", 32'(exp_q.size()), 0);

        // 4: 32b command with gapped so_valid, not last in frame
        sti_gap = 1'b1;
        nd = n_done;
        b  = n_load;
        drive_cmd(16'h3C5A, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        wait_loads(b + 1, "t4_load");
        wait_xfers(6, "t4_xfer");
        repeat (2) @(negedge clk);
        chk("t4_pop_timing", 32'(last_busy_cyc - load_cyc[b]), 65);
        chk("t4_no_done", 32'(n_done), 32'(nd));
        chk("t4_hold", 32'(hold_err), 0);
        sti_gap = 1'b0;

        // 5: reset during SHIFT of a 24b transfer with a second command queued
        nd = n_done;
        b  = n_load;
        drive_cmd(16'hBEEF, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        drive_cmd(16'h0BAD, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        wait_loads(b + 1, "t5_load");
        k = load_cyc[b];
        while (cyc < k + 12) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_rst_outputs", 32'({load, busy, done, err, cmd_ready, w_pi}), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        b = n_load;
        repeat (6) @(negedge clk);
        chk("t5_fifo_empty", 32'(n_load), 32'(b));
        chk("t5_no_done", 32'(n_done), 32'(nd));
        drive_cmd(16'h5A5A, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        cmd_valid = 1'b0;
        wait_loads(b + 1, "t5_reload");
        wait_xfers(7, "t5_xfer");
        finish_frame("t5");
        chk("err_clear", 32'(err), 0);

`ifdef STI_WDOG_EN
        // 6: watchdog with no so_valid
        sti_en = 1'b0;
        b = n_load;
        drive_cmd(16'h0F0F, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        wait_loads(b + 1, "t6_load");
        k = load_cyc[b];
        while (cyc < k + 64) @(negedge clk);
        chk("t6_err_early", 32'(err), 0);
        @(negedge clk);
        chk("t6_err", 32'(err), 1);
        chk("t6_idle", 32'(busy), 0);
        repeat (5) @(negedge clk);
        chk("t6_head_dropped", 32'(n_load - b), 1);
        sti_en = 1'b1;
        drive_cmd(16'h7E7E, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        wait_xfers(8, "t6_xfer");
        finish_frame("t6");
        chk("t6_sticky", 32'(err), 1);
        chk("done_total", 32'(n_done), 4);
`else
        chk("done_total", 32'(n_done), 3);
`endif
        chk("hold_total", 32'(hold_err), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
